// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the digit-serial subtractor: controller states and
// the sizing rule for the digit counter.
package serial_subtractor_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Counter must hold 0 .. WIDTH/DIGIT-1; keep at least one bit for single-pass use.
  function automatic int cnt_width(input int width, input int digit);
    int n_digits;
    n_digits = width / digit;
    if ($clog2(n_digits) < 1) begin
      return 1;
    end else begin
      return $clog2(n_digits);
    end
  endfunction

endpackage

// File: rtl/serial_subtractor_fs_bit.sv
// Combinational full-subtractor cell: one bit of x - y - bi.
module fs_bit (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, diff = a - b - bin, DIGIT bits per clock
// LSB digit first, with start/done handshake and registered results.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(WIDTH, DIGIT);
  localparam logic [CW-1:0] LAST_CNT = CW'(NDIG - 1);

  if (((WIDTH % DIGIT) != 0) || (WIDTH < 2)) begin : g_bad_params
    $fatal(1, "serial_subtractor: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_work;
  logic [WIDTH-1:0] b_work;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             borrow;
  logic             sm_work;
  logic [DIGIT:0]   chain;
  logic [DIGIT-1:0] d_dig;
  logic             last_digit;

  assign chain[0]   = borrow;
  assign last_digit = (cnt == LAST_CNT);

  for (genvar i = 0; i < DIGIT; i++) begin : g_cells
    fs_bit u_fs_bit (
      .x  (a_work[i]),
      .y  (b_work[i]),
      .bi (chain[i]),
      .d  (d_dig[i]),
      .bo (chain[i+1])
    );
  end

  // New digit enters at the top; after NDIG shifts the LSB digit sits at bit 0.
  if (DIGIT == WIDTH) begin : g_single_pass
    assign res_next = d_dig;
  end else begin : g_multi_pass
    assign res_next = {d_dig, res[WIDTH-1:DIGIT]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (last_digit) begin
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, digit processing and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= {CW{1'b0}};
      a_work  <= {WIDTH{1'b0}};
      b_work  <= {WIDTH{1'b0}};
      res     <= {WIDTH{1'b0}};
      borrow  <= 1'b0;
      sm_work <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= {WIDTH{1'b0}};
      bout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_work  <= a;
            b_work  <= b;
            borrow  <= bin;
            sm_work <= signed_mode;
            cnt     <= {CW{1'b0}};
            busy    <= 1'b1;
          end
        end
        RUN: begin
          a_work <= a_work >> DIGIT;
          b_work <= b_work >> DIGIT;
          borrow <= chain[DIGIT];
          res    <= res_next;
          if (last_digit) begin
            cnt  <= {CW{1'b0}};
            diff <= res_next;
            bout <= chain[DIGIT];
            // chain[DIGIT-1] is the borrow entering bit WIDTH-1 on the final digit.
            ovf  <= sm_work ? (chain[DIGIT-1] ^ chain[DIGIT]) : chain[DIGIT];
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

- Parametrised, multi-cycle N-bit subtractor computing `diff = a - b - bin`.
- Built from a replicated full-subtractor bit cell; processes `DIGIT` bits per clock, LSB digit first, with a start/done handshake.
- Successor to the single-bit full subtractor: arbitrary operand width, selectable throughput, borrow-in, signed overflow detection and registered results.
- Sits in the arithmetic datapath where area matters more than latency.

## Interface

Parameters:
- `WIDTH`, default 8: operand/result width in bits; must be ≥ 2.
- `DIGIT`, default 1: bits processed per clock; must divide `WIDTH`. `DIGIT = WIDTH` gives single-pass operation.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: request; sampled only when `busy` = 0.
- `a`, input, WIDTH: minuend; captured on the accepted `start`.
- `b`, input, WIDTH: subtrahend; captured on the accepted `start`.
- `bin`, input, 1: borrow-in; captured on the accepted `start`.
- `signed_mode`, input, 1: selects overflow rule; captured on the accepted `start`.
- `busy`, output, 1: high while an operation is in progress.
- `done`, output, 1: one-cycle pulse; results are valid from this cycle onward.
- `diff`, output, WIDTH: difference; held until the next completion.
- `bout`, output, 1: borrow-out of the MSB.
- `ovf`, output, 1: overflow. Equals `bout` when `signed_mode` = 0; equals borrow-into-MSB XOR borrow-out-of-MSB when `signed_mode` = 1.

## Operation

- States: `IDLE` and `RUN`.
- **`IDLE`:**
  - `busy` = 0.
  - On an edge with `start` = 1: latch `a`, `b`, `bin` and `signed_mode` into working registers, clear the digit counter, go to `RUN`.
- **`RUN`:**
  - Each edge feeds the current `DIGIT` bits of the working `a` and `b` and the running borrow through `DIGIT` chained bit cells.
  - Write the difference bits into the result shift register; update the running borrow; advance the counter.
  - After the last digit (counter = `WIDTH/DIGIT - 1`), update `diff`, `bout` and `ovf`, pulse `done`, and return to `IDLE`.
- Borrow into MSB: the borrow entering bit `WIDTH-1`, captured from the cell chain on the final digit.
- `start` while `busy` = 1 is ignored; there is no queueing.
- `diff`, `bout` and `ovf` change only on the completion edge. Intermediate digits are never visible on the outputs.
- Arithmetic is modulo 2^WIDTH. `bout` = 1 exactly when `a < b + bin` (unsigned).

## Timing

- Reset values: state `IDLE`, `busy` 0, `done` 0, `diff` 0, `bout` 0, `ovf` 0, counter 0.
- Let E0 be the edge that accepts `start`:
  - `busy` is high after E0.
  - The completion edge is E0 + `WIDTH/DIGIT`.
  - `done` is high for exactly the cycle following the completion edge, and `busy` is low in that cycle.
  - Latency from `start` to `done`: `WIDTH/DIGIT` cycles.
- Back-to-back: a `start` asserted during the `done` cycle is accepted, giving no dead cycle between operations.
- `rst` mid-operation: abort, discard working state, drive all outputs to their reset values on that edge. A `start` in the same cycle as `rst` is ignored.
- `done` is never asserted without a preceding accepted `start`.

## Structure

- Shared arithmetic package holds:
  - the state enumeration (`IDLE`, `RUN`);
  - a function computing the counter width, `clog2(WIDTH/DIGIT)`, minimum 1.
- One natural sub-module, `fs_bit`: combinational full-subtractor cell.
  - Inputs `x`, `y`, `bi`.
  - Outputs `d = x ^ y ^ bi` and `bo = (~x & y) | (~(x ^ y) & bi)`.
  - Instantiated `DIGIT` times in a generate loop.
- Elaboration-time check: `WIDTH % DIGIT == 0`, else fatal.

## Test plan

- `WIDTH` = 8, `DIGIT` = 1; `a` = 0x05, `b` = 0x03, `bin` = 0, unsigned.
  - Expect `busy` for 8 cycles, then `done` pulse with `diff` = 0x02, `bout` = 0, `ovf` = 0.
- `a` = 0x03, `b` = 0x05, unsigned.
  - Expect `diff` = 0xFE, `bout` = 1, `ovf` = 1.
- `bin` = 1, `a` = 0x00, `b` = 0x00.
  - Expect `diff` = 0xFF, `bout` = 1.
- Signed: `a` = 0x80, `b` = 0x01 → `diff` = 0x7F, `ovf` = 1.
- Signed: `a` = 0x7F, `b` = 0xFF → `diff` = 0x80, `ovf` = 1.
- Signed: `a` = 0x10, `b` = 0x20 → `diff` = 0xF0, `ovf` = 0.
- `rst` 3 cycles after `start` (`a` = 0x55, `b` = 0x11).
  - Expect all outputs 0, no `done`.
  - Then a `start` with `a` = 0x10, `b` = 0x01 completes normally with `diff` = 0x0F.
- `WIDTH` = 8, `DIGIT` = 4.
  - Expect `done` 2 cycles after `start`.
  - A second `start` issued in the `done` cycle is accepted.
  - A `start` pulsed while `busy` is ignored.
  - Randomised 1000 operations match `a - b - bin` against a reference model.
